// File: rtl/fp_reduce_stage.sv
// fp_reduce_stage: 3-stage BN254 modular correction of a raw 272-bit add/sub result.
// Define FP_REDUCE_RANGE_CHECK_EN to compile in the o_err (result >= P) range check.
typedef logic [271:0] uint_fp_t;

module fp_reduce_stage #(
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic             i_sub,
  input  uint_fp_t         i_Z,
  input  logic             i_carry,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             o_ready,
  output uint_fp_t         o_Z,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_err
);
  localparam int unsigned LimbW = 68;
  localparam uint_fp_t P =
      272'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

  // Stage control
  logic v1_q, v2_q, v3_q;
  logic adv1, adv2, adv3;
  logic s1_load, s2_load, s3_load;

  always_comb begin
    adv3    = !v3_q || o_ready;
    adv2    = !v2_q || adv3;
    adv1    = !v1_q || adv2;
    i_ready = rstn && adv1;
    s1_load = adv1 && i_valid;
    s2_load = adv2 && v1_q;
    s3_load = adv3 && v2_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      if (adv1) v1_q <= i_valid;
      if (adv2) v2_q <= v1_q;
      if (adv3) v3_q <= v2_q;
    end
  end

  // S1: limb-wise z - P with per-limb borrow
  uint_fp_t              s1_z_q;
  logic                  s1_sub_q, s1_carry_q;
  logic [TAG_W-1:0]      s1_tag_q;
  logic [3:0][LimbW-1:0] s1_dl_d, s1_dl_q;
  logic [3:0]            s1_db_d, s1_db_q;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      {s1_db_d[k], s1_dl_d[k]} = {1'b0, i_Z[k*LimbW +: LimbW]} - {1'b0, P[k*LimbW +: LimbW]};
    end
  end

  // S2: merge borrows into 136-bit halves, form limb sums of z + P
  uint_fp_t              s2_z_q;
  logic                  s2_sub_q, s2_carry_q;
  logic [TAG_W-1:0]      s2_tag_q;
  logic [LimbW:0]        t_lo, t_hi;
  logic [2*LimbW-1:0]    s2_slo_d, s2_slo_q, s2_shi_d, s2_shi_q;
  logic                  s2_slob_d, s2_slob_q, s2_shib_d, s2_shib_q;
  logic [3:0][LimbW-1:0] s2_al_d, s2_al_q;
  logic [2:0]            s2_ac_d, s2_ac_q;

  always_comb begin
    t_lo      = {1'b0, s1_dl_q[1]} - {{LimbW{1'b0}}, s1_db_q[0]};
    s2_slo_d  = {t_lo[LimbW-1:0], s1_dl_q[0]};
    s2_slob_d = s1_db_q[1] | t_lo[LimbW];
    t_hi      = {1'b0, s1_dl_q[3]} - {{LimbW{1'b0}}, s1_db_q[2]};
    s2_shi_d  = {t_hi[LimbW-1:0], s1_dl_q[2]};
    s2_shib_d = s1_db_q[3] | t_hi[LimbW];
    for (int k = 0; k < 3; k++) begin
      {s2_ac_d[k], s2_al_d[k]} = {1'b0, s1_z_q[k*LimbW +: LimbW]} + {1'b0, P[k*LimbW +: LimbW]};
    end
    // Top limb carry-out falls off the mod 2^272 result
    s2_al_d[3] = s1_z_q[3*LimbW +: LimbW] + P[3*LimbW +: LimbW];
  end

  // S3: final merge and select
  logic [2*LimbW:0] t_full;
  uint_fp_t         sub_res, add_res, carry_vec, res;
  logic             sub_borrow;

  always_comb begin
    t_full     = {1'b0, s2_shi_q} - {{2*LimbW{1'b0}}, s2_slob_q};
    sub_res    = {t_full[2*LimbW-1:0], s2_slo_q};
    sub_borrow = s2_shib_q | t_full[2*LimbW];
    carry_vec  = '0;
    for (int k = 0; k < 3; k++) begin
      carry_vec[(k+1)*LimbW] = s2_ac_q[k];
    end
    add_res = s2_al_q + carry_vec;
    if (!s2_sub_q) res = (s2_carry_q || !sub_borrow) ? sub_res : s2_z_q;
    else           res = s2_carry_q ? s2_z_q : add_res;
  end

  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_z_q     <= i_Z;
      s1_sub_q   <= i_sub;
      s1_carry_q <= i_carry;
      s1_tag_q   <= i_tag;
      s1_dl_q    <= s1_dl_d;
      s1_db_q    <= s1_db_d;
    end
    if (s2_load) begin
      s2_z_q     <= s1_z_q;
      s2_sub_q   <= s1_sub_q;
      s2_carry_q <= s1_carry_q;
      s2_tag_q   <= s1_tag_q;
      s2_slo_q   <= s2_slo_d;
      s2_slob_q  <= s2_slob_d;
      s2_shi_q   <= s2_shi_d;
      s2_shib_q  <= s2_shib_d;
      s2_al_q    <= s2_al_d;
      s2_ac_q    <= s2_ac_d;
    end
  end

  uint_fp_t         o_z_q;
  logic [TAG_W-1:0] o_tag_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_z_q   <= '0;
      o_tag_q <= '0;
    end else if (s3_load) begin
      o_z_q   <= res;
      o_tag_q <= s2_tag_q;
    end
  end

  assign o_valid = v3_q;
  assign o_Z     = o_z_q;
  assign o_tag   = o_tag_q;

`ifdef FP_REDUCE_RANGE_CHECK_EN
  logic o_err_d, o_err_q;

  always_comb o_err_d = (res >= P);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        o_err_q <= 1'b0;
    else if (s3_load) o_err_q <= o_err_d;
  end

  assign o_err = o_err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule
